// File: rtl/unidade_controle_if.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_controle_if
//  Description : Fetch handshake and datapath-control bundle of the control unit
//  Revision    : 1.0 - initial release
// ============================================================================
interface unidade_controle_if #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2,
  parameter int bits_pc       = 8
);
  logic                     run;
  logic                     instr_valid;
  logic [bits_palavra-1:0]  instr_data;
  logic                     instr_req;
  logic [bits_pc-1:0]       pc;
  logic                     Hab_Escrita;
  logic [end_registros-1:0] Sel_SA;
  logic [end_registros-1:0] Sel_SB;
  logic [end_registros-1:0] Sel_SC;
  logic [4:0]               controleOperacao;
  logic                     reset_Ban_Registros;
  logic                     reset_Flags;
  logic                     halted;

  modport master (
    output run, instr_valid, instr_data,
    input  instr_req, pc, Hab_Escrita, Sel_SA, Sel_SB, Sel_SC,
           controleOperacao, reset_Ban_Registros, reset_Flags, halted
  );

  modport slave (
    input  run, instr_valid, instr_data,
    output instr_req, pc, Hab_Escrita, Sel_SA, Sel_SB, Sel_SC,
           controleOperacao, reset_Ban_Registros, reset_Flags, halted
  );
endinterface
`default_nettype wire

// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_controle
//  Description : Multi-cycle control unit (fetch/decode/execute/writeback/halt)
//  Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2,
  parameter int bits_pc       = 8
) (
  input  wire                clk,
  input  wire                reset,
  unidade_controle_if.slave  bus
);

  localparam int OP_LSB = bits_palavra - 5;
  localparam int RC_LSB = OP_LSB - end_registros;
  localparam int RA_LSB = RC_LSB - end_registros;
  localparam int RB_LSB = RA_LSB - end_registros;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  state_t                  state_q;
  logic [bits_pc-1:0]      pc_q;
  logic [bits_palavra-1:0] ir_q;
  logic                    hab_q;
  logic                    clr_q;
  logic                    halted_q;

  logic [4:0] w_op;
  logic       w_accept;
  logic       unused_bits;

  assign w_op        = ir_q[OP_LSB +: 5];
  assign w_accept    = (state_q == ST_FETCH) && bus.run && bus.instr_valid;
  assign unused_bits = ^ir_q[RB_LSB-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      pc_q     <= '0;
      ir_q     <= '0;
      hab_q    <= 1'b0;
      clr_q    <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_q   <= 1'b0;
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (w_accept) begin
            ir_q    <= bus.instr_data;
            pc_q    <= pc_q + bits_pc'(1);
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            state_q  <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (w_op == OP_NOP) begin
            state_q <= ST_FETCH;
          end else begin
            hab_q   <= 1'b1;
            state_q <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          hab_q   <= 1'b0;
          state_q <= ST_FETCH;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          hab_q   <= 1'b0;
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  // Reset masks the outputs in the very cycle it is raised, before the edge clears the registers.
  assign bus.instr_req           = (state_q == ST_FETCH) && bus.run && !reset;
  assign bus.Hab_Escrita         = hab_q && !reset;
  assign bus.reset_Ban_Registros = clr_q && !reset;
  assign bus.reset_Flags         = clr_q && !reset;
  assign bus.halted              = halted_q;
  assign bus.pc                  = pc_q;
  assign bus.controleOperacao    = reset ? 5'd0 : w_op;
  assign bus.Sel_SC              = reset ? '0 : ir_q[RC_LSB +: end_registros];
  assign bus.Sel_SA              = reset ? '0 : ir_q[RA_LSB +: end_registros];
  assign bus.Sel_SB              = reset ? '0 : ir_q[RB_LSB +: end_registros];

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidade_controle
//  Description : Randomized self-checking bench with a schedule-based reference
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle;

  localparam int INF = 1000000000;

  logic clk;
  logic reset;

  unidade_controle_if #(.bits_palavra(16), .end_registros(2), .bits_pc(8)) bus ();

  unidade_controle #(.bits_palavra(16), .end_registros(2), .bits_pc(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: instruction timing as a schedule of future cycle numbers.
  int cyc      = 0;
  int init_cyc = -1;
  int free_at  = INF;
  int wr_cyc   = -1;
  int halt_at  = INF;
  int pc_m     = 0;
  int op_m     = 0;
  int sa_m     = 0;
  int sb_m     = 0;
  int sc_m     = 0;
  bit halted_m = 1'b0;
  bit prev_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ru, input logic v, input logic [15:0] d);
    bit exp_req;
    int op;
    @(negedge clk);
    reset           = r;
    bus.run         = ru;
    bus.instr_valid = v;
    bus.instr_data  = d;
    #1;
    if (r) begin
      chk("hab_rst",  32'(bus.Hab_Escrita), 32'd0);
      chk("req_rst",  32'(bus.instr_req), 32'd0);
      chk("sa_rst",   32'(bus.Sel_SA), 32'd0);
      chk("sb_rst",   32'(bus.Sel_SB), 32'd0);
      chk("sc_rst",   32'(bus.Sel_SC), 32'd0);
      chk("op_rst",   32'(bus.controleOperacao), 32'd0);
      chk("clrb_rst", 32'(bus.reset_Ban_Registros), 32'd0);
      if (prev_rst) begin
        chk("halted_rst", 32'(bus.halted), 32'd0);
        chk("pc_rst",     32'(bus.pc), 32'd0);
      end
      pc_m = 0; op_m = 0; sa_m = 0; sb_m = 0; sc_m = 0;
      halted_m = 1'b0;
      init_cyc = cyc + 1;
      free_at  = cyc + 2;
      wr_cyc   = -1;
      halt_at  = INF;
      prev_rst = 1'b1;
    end else begin
      halted_m = (cyc >= halt_at);
      exp_req  = ru && (cyc >= free_at) && !halted_m;
      chk("clr_ban",   32'(bus.reset_Ban_Registros), 32'(cyc == init_cyc));
      chk("clr_flags", 32'(bus.reset_Flags), 32'(cyc == init_cyc));
      chk("instr_req", 32'(bus.instr_req), 32'(exp_req));
      chk("hab",       32'(bus.Hab_Escrita), 32'(cyc == wr_cyc));
      chk("pc",        32'(bus.pc), 32'(pc_m));
      chk("halted",    32'(bus.halted), 32'(halted_m));
      chk("sel_sa",    32'(bus.Sel_SA), 32'(sa_m));
      chk("sel_sb",    32'(bus.Sel_SB), 32'(sb_m));
      chk("sel_sc",    32'(bus.Sel_SC), 32'(sc_m));
      chk("op",        32'(bus.controleOperacao), 32'(op_m));
      if (exp_req && v) begin
        op   = int'(d) / 2048;
        op_m = op;
        sc_m = (int'(d) / 512) % 4;
        sa_m = (int'(d) / 128) % 4;
        sb_m = (int'(d) / 32) % 4;
        pc_m = (pc_m + 1) % 256;
        if (op == 31) begin
          halt_at = cyc + 2;
          free_at = INF;
        end else if (op == 0) begin
          free_at = cyc + 3;
        end else begin
          wr_cyc  = cyc + 3;
          free_at = cyc + 4;
        end
      end
      prev_rst = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 16'hFFFF);
  endtask

  initial begin
    reset = 1'b1; bus.run = 1'b0; bus.instr_valid = 1'b0; bus.instr_data = '0;

    // Basic instruction stream after a two-cycle reset
    step(1'b1, 1'b1, 1'b1, 16'h0ACC);
    step(1'b1, 1'b1, 1'b1, 16'h0ACC);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 16'h0ACC);

    // run low blocks fetch, then resume
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 16'h1234);

    // NOP followed by a real op
    idle(4);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 16'h3E60);

    // Randomized traffic, no HALT, rare resets
    for (int i = 0; i < 300; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:11] = 5'($urandom_range(0, 30));
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
           1'($urandom), w);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);

    // HALT: frozen despite run/valid, left only through reset
    idle(4);
    step(1'b0, 1'b1, 1'b1, 16'hF800);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 16'h0ACC);
    step(1'b1, 1'b1, 1'b1, 16'h0ACC);
    step(1'b1, 1'b1, 1'b1, 16'h0ACC);

    // pc wrap after 256 accepted NOPs
    for (int i = 0; i < 256 * 3 + 4; i++) step(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("pc_wrapped_model", 32'(bus.pc), 32'(pc_m));

    // Reset raised in the WRITEBACK cycle
    idle(4);
    step(1'b0, 1'b1, 1'b1, 16'h0ACC);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- bits_palavra, 16, instruction word width
- end_registros, 2, register-bank address width
- bits_pc, 8, program-counter width
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  permits instruction fetch while high
- instr_valid  in  1  instr_data is valid this cycle
- instr_data  in  bits_palavra  instruction word
- instr_req  out  1  requests an instruction
- pc  out  bits_pc  fetch address
- Hab_Escrita  out  1  datapath register-bank write enable
- Sel_SA  out  end_registros  read-port A address
- Sel_SB  out  end_registros  read-port B address
- Sel_SC  out  end_registros  write address
- controleOperacao  out  5  ALU operation select
- reset_Ban_Registros  out  1  register-bank clear
- reset_Flags  out  1  flag-register clear
- halted  out  1  HALT executed

Function
REQ-003 The instruction format SHALL be: [15:11] op, [10:9] rc (write), [8:7] ra, [6:5] rb, [4:0] ignored.
REQ-004 The FSM SHALL have the states INIT, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-005 INIT SHALL assert reset_Ban_Registros=1 and reset_Flags=1 for exactly one cycle, then go to FETCH.
REQ-006 In FETCH, instr_req SHALL equal run; an instruction SHALL be accepted only in a cycle where instr_req=1 and instr_valid=1.
REQ-007 instr_valid SHALL be ignored outside FETCH or while run=0.
REQ-008 On acceptance, the block SHALL latch instr_data into an internal instruction register, increment pc by 1 (bits_pc-bit wrap, 255->0 at default), and go to DECODE.
REQ-009 DECODE SHALL last one cycle, drive Sel_SA=ra, Sel_SB=rb, Sel_SC=rc and controleOperacao=op from the latched word, and go to EXECUTE.
REQ-010 EXECUTE SHALL hold the same selects and op for one cycle with Hab_Escrita=0, then go to WRITEBACK.
REQ-011 WRITEBACK SHALL assert Hab_Escrita=1 for exactly one cycle with the selects and op unchanged, then go to FETCH.
REQ-012 For op=5'b00000 (NOP), EXECUTE SHALL go directly to FETCH and Hab_Escrita SHALL stay 0.
REQ-013 For op=5'b11111 (HALT), DECODE SHALL go to HALT.
REQ-014 In HALT: halted=1, instr_req=0, Hab_Escrita=0, pc frozen; HALT SHALL be left only through reset.
REQ-015 Latency from the acceptance edge to the Hab_Escrita pulse SHALL be 3 cycles; throughput SHALL be one instruction per 4 cycles with instr_valid held high.
REQ-016 Sel_SA, Sel_SB, Sel_SC and controleOperacao SHALL hold their last values in FETCH.
REQ-017 Hab_Escrita SHALL never be 1 outside WRITEBACK.
REQ-018 Deasserting run mid-instruction SHALL not abort it; it only blocks the next fetch.

Reset
REQ-019 While reset=1, on every clk edge: state<=INIT, pc<=0, instruction register<=0, halted<=0.
REQ-020 While reset=1: Hab_Escrita=0, instr_req=0, Sel_*=0, controleOperacao=0.
REQ-021 Reset SHALL take priority over every transition, including mid-WRITEBACK and in HALT; the first cycle after release SHALL be INIT.

Verification
REQ-022 Reset 2 cycles, run=1, instr_valid=1, instr_data=16'h0ACC (op=1, rc=1, ra=1, rb=2) -> one INIT cycle with both clears high; pc 0->1; Sel_SA=1, Sel_SB=2, Sel_SC=1, op=1; Hab_Escrita high exactly 3 cycles after acceptance.
REQ-023 run=0 with instr_valid=1 for 5 cycles -> instr_req=0, pc unchanged, no write; run=1 -> accepted next cycle.
REQ-024 NOP 16'h0000 followed by a valid op -> no Hab_Escrita for the NOP; second instruction accepted 3 cycles after the first.
REQ-025 HALT 16'hF800 -> halted=1 two cycles after acceptance; instr_req=0 and pc constant for 10 cycles despite run=1; reset -> halted=0, pc=0.
REQ-026 Preload pc=255 via 255 accepted NOPs, then accept one more -> pc wraps to 0.
REQ-027 reset asserted during WRITEBACK -> Hab_Escrita=0 in that cycle; next state INIT; no further write.
